// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router ingress path.
//   - default sizing (ports, byte width, length field width)
//   - header field positions
//   - ingress FSM state encoding
package router_pkg;

    localparam int unsigned NUM_PORTS_DEF = 3;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned LEN_W_DEF     = 6;

    // Header byte layout: [7:2] payload length, [1:0] destination address
    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_ADDR_MSB = 1;
    localparam int unsigned HDR_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_WAIT_EMPTY = 3'd2,
        ST_LOAD       = 3'd3,
        ST_DROP       = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

endpackage

// File: rtl/router_pkt_reg.sv
// Per-packet bookkeeping for the ingress FSM: header latch, running parity,
// remaining-length counter with over-length flag, and the end-of-packet
// status pulses.
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   load            header beat accepted: latch header, seed parity and length
//   update          payload beat accepted: fold into parity, count down
//   finish          parity beat accepted: register error/done pulses
//   clear           drop packet context
//   data            byte accepted this cycle
//   hdr             latched header
//   parity_err      1-cycle pulse, received parity != computed parity
//   len_err         1-cycle pulse, payload count != header length
//   pkt_done        1-cycle pulse, packet fully written
module router_pkt_reg
    import router_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              update,
    input  logic              finish,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] hdr,
    output logic              parity_err,
    output logic              len_err,
    output logic              pkt_done
);

    logic [DATA_W-1:0] par;
    logic [LEN_W-1:0]  cnt;
    logic              over_len;

    // Context registers; status outputs are single-cycle pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hdr        <= '0;
            par        <= '0;
            cnt        <= '0;
            over_len   <= 1'b0;
            parity_err <= 1'b0;
            len_err    <= 1'b0;
            pkt_done   <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            len_err    <= 1'b0;
            pkt_done   <= 1'b0;
            if (clear) begin
                hdr      <= '0;
                par      <= '0;
                cnt      <= '0;
                over_len <= 1'b0;
            end else if (load) begin
                hdr      <= data;
                par      <= data;
                cnt      <= LEN_W'(data[HDR_LEN_MSB:HDR_LEN_LSB]);
                over_len <= 1'b0;
            end else if (update) begin
                par <= par ^ data;
                // Counter saturates; a beat past the advertised length is remembered
                if (cnt == '0) begin
                    over_len <= 1'b1;
                end else begin
                    cnt <= cnt - LEN_W'(1);
                end
            end else if (finish) begin
                parity_err <= (data != par);
                len_err    <= (cnt != '0) || over_len;
                pkt_done   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_ingress_fsm.sv
// Ingress controller of the 1x3 router: decodes the header, steers bytes to
// one destination FIFO, tags the header write, back-pressures the source and
// reports parity/length errors. Packets to an invalid address are dropped.
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   data_in         source byte
//   in_valid        data_in valid
//   in_last         current beat is the parity byte
//   busy            source must hold (transfer iff in_valid && !busy)
//   fifo_full       per-FIFO full
//   fifo_empty      per-FIFO empty
//   soft_reset      per-FIFO flush request
//   write_enb       one-hot FIFO write strobe
//   lfd_state       marks the header write
//   fifo_data       byte presented to the FIFOs
//   parity_err      1-cycle parity error pulse
//   len_err         1-cycle length error pulse
//   pkt_done        1-cycle packet complete pulse
module router_ingress_fsm
    import router_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned LEN_W     = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 busy,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 lfd_state,
    output logic [DATA_W-1:0]    fifo_data,
    output logic                 parity_err,
    output logic                 len_err,
    output logic                 pkt_done
);

    localparam int unsigned ADDR_W = HDR_ADDR_MSB - HDR_ADDR_LSB + 1;

    state_t                state;
    state_t                next_state;
    logic [DATA_W-1:0]     hdr;
    logic [ADDR_W-1:0]     addr;
    logic                  addr_ok;
    logic [NUM_PORTS-1:0]  sel;
    logic                  tgt_full;
    logic                  tgt_empty;
    logic                  tgt_srst;
    logic                  xfer;
    logic                  hdr_load;
    logic                  pay_upd;
    logic                  pkt_fin;
    logic                  pkt_clr;

    router_pkt_reg #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_pkt_reg (
        .clk        (clk),
        .resetn     (resetn),
        .load       (hdr_load),
        .update     (pay_upd),
        .finish     (pkt_fin),
        .clear      (pkt_clr),
        .data       (data_in),
        .hdr        (hdr),
        .parity_err (parity_err),
        .len_err    (len_err),
        .pkt_done   (pkt_done)
    );

    // Destination decode; an out-of-range address selects no FIFO
    always_comb begin
        addr      = hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
        addr_ok   = (32'(addr) < NUM_PORTS);
        sel       = addr_ok ? (NUM_PORTS'(1) << addr) : '0;
        tgt_full  = |(fifo_full  & sel);
        tgt_empty = |(fifo_empty & sel);
        tgt_srst  = |(soft_reset & sel);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, write steering and bookkeeping strobes
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        write_enb  = '0;
        lfd_state  = 1'b0;
        fifo_data  = '0;
        hdr_load   = 1'b0;
        pay_upd    = 1'b0;
        pkt_fin    = 1'b0;
        pkt_clr    = 1'b0;
        xfer       = 1'b0;

        case (state)
            ST_IDLE: begin
                // in_last on a header beat is ignored: the beat is a header
                if (in_valid) begin
                    hdr_load   = 1'b1;
                    next_state = ST_CHECK;
                end
            end

            ST_CHECK: begin
                busy = 1'b1;
                if (!addr_ok) begin
                    next_state = ST_DROP;
                end else if (tgt_empty) begin
                    write_enb  = sel;
                    lfd_state  = 1'b1;
                    fifo_data  = hdr;
                    next_state = ST_LOAD;
                end else begin
                    next_state = ST_WAIT_EMPTY;
                end
            end

            ST_WAIT_EMPTY: begin
                busy = 1'b1;
                if (tgt_srst) begin
                    next_state = ST_DROP;
                end else if (tgt_empty) begin
                    write_enb  = sel;
                    lfd_state  = 1'b1;
                    fifo_data  = hdr;
                    next_state = ST_LOAD;
                end
            end

            ST_LOAD: begin
                busy = tgt_full;
                xfer = in_valid && !tgt_full;
                if (tgt_srst) begin
                    // Flush: a beat taken this cycle is discarded with the rest
                    if (xfer && in_last) begin
                        pkt_clr    = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_DROP;
                    end
                end else if (xfer) begin
                    write_enb = sel;
                    fifo_data = data_in;
                    if (in_last) begin
                        pkt_fin    = 1'b1;
                        next_state = ST_DONE;
                    end else begin
                        pay_upd = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                busy       = 1'b1;
                next_state = ST_IDLE;
            end

            ST_DROP: begin
                if (in_valid && in_last) begin
                    pkt_clr    = 1'b1;
                    next_state = ST_IDLE;
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_router_ingress_fsm.sv
// Self-checking bench for router_ingress_fsm. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge. Expected FIFO
// writes and end-of-packet status are queued by the driver and consumed by a
// monitor as the DUT produces them.
module tb_router_ingress_fsm;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [2:0] we;
        logic       lfd;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic pe;
        logic le;
    } fl_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] data_in;
    logic       in_valid;
    logic       in_last;
    logic       busy;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic [7:0] fifo_data;
    logic       parity_err;
    logic       len_err;
    logic       pkt_done;

    int total = 0;
    int bad   = 0;

    wr_t exp_wr[$];
    fl_t exp_fl[$];

    router_ingress_fsm dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .fifo_data  (fifo_data),
        .parity_err (parity_err),
        .len_err    (len_err),
        .pkt_done   (pkt_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] port_sel(input logic [7:0] hdr);
        logic [2:0] one;
        one = 3'b001;
        return (hdr[1:0] < 2'd3) ? (one << hdr[1:0]) : 3'b000;
    endfunction

    task automatic push_wr(input logic [2:0] sel, input logic lfd, input logic [7:0] d);
        if (sel != 3'b000) exp_wr.push_back('{we: sel, lfd: lfd, d: d});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until accepted; w = cycles stalled by busy
    task automatic beat(input logic [7:0] d, input logic l, output int w);
        in_valid = 1'b1;
        data_in  = d;
        in_last  = l;
        w = 0;
        @(negedge clk);
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy) check_eq("beat_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input bq_t pl, input logic bad_par,
                            output int stalls);
        logic [7:0] x;
        logic [7:0] lastb;
        logic [2:0] sel;
        int         w;
        sel    = port_sel(hdr);
        x      = hdr;
        stalls = 0;
        push_wr(sel, 1'b1, hdr);
        beat(hdr, 1'b0, w);
        stalls += w;
        foreach (pl[i]) begin
            x ^= pl[i];
            push_wr(sel, 1'b0, pl[i]);
            beat(pl[i], 1'b0, w);
            stalls += w;
        end
        lastb = bad_par ? (x ^ 8'h03) : x;
        push_wr(sel, 1'b0, lastb);
        if (sel != 3'b000)
            exp_fl.push_back('{pe: (lastb != x), le: (pl.size() != int'(hdr[7:2]))});
        beat(lastb, 1'b1, w);
        stalls += w;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: every write and every status pulse must be anticipated
    always @(negedge clk) begin
        if (resetn) begin
            if (write_enb != 3'b000) begin
                if (exp_wr.size() == 0) begin
                    check_eq("wr_unexpected", 32'(write_enb), 32'd0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check_eq("wr_port", 32'(write_enb), 32'(e.we));
                    check_eq("wr_lfd",  32'(lfd_state), 32'(e.lfd));
                    check_eq("wr_data", 32'(fifo_data), 32'(e.d));
                end
            end else if (lfd_state) begin
                check_eq("lfd_without_write", 32'(lfd_state), 32'd0);
            end
            if (pkt_done) begin
                if (exp_fl.size() == 0) begin
                    check_eq("done_unexpected", 32'(pkt_done), 32'd0);
                end else begin
                    fl_t f;
                    f = exp_fl.pop_front();
                    check_eq("parity_err", 32'(parity_err), 32'(f.pe));
                    check_eq("len_err",    32'(len_err),    32'(f.le));
                end
            end else if (parity_err || len_err) begin
                check_eq("flag_without_done", 32'({parity_err, len_err}), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t        q;
        int         st;
        int         w;
        logic [7:0] x;

        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        soft_reset = 3'b000;

        // Reset state
        idle(2);
        @(negedge clk);
        check_eq("rst_busy",  32'(busy),       32'd0);
        check_eq("rst_we",    32'(write_enb),  32'd0);
        check_eq("rst_lfd",   32'(lfd_state),  32'd0);
        check_eq("rst_data",  32'(fifo_data),  32'd0);
        check_eq("rst_flags", 32'({parity_err, len_err, pkt_done}), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(2);

        // Good packet to port 1
        q = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'h0D, q, 1'b0, st);
        check_eq("p1_stalls", 32'(st), 32'd1);
        idle(3);

        // Same packet, corrupted parity byte
        send_pkt(8'h0D, q, 1'b1, st);
        idle(3);

        // Port 2 goes full for 4 cycles while the 2nd payload beat is offered
        q = '{8'h44, 8'h55, 8'h66};
        fork
            send_pkt(8'h0E, q, 1'b0, st);
            begin
                repeat (3) @(posedge clk);
                #1;
                fifo_full[2] = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check_eq("full_busy", 32'(busy),      32'd1);
                    check_eq("full_nowe", 32'(write_enb), 32'd0);
                    @(posedge clk);
                    #1;
                end
                fifo_full[2] = 1'b0;
            end
        join
        check_eq("full_stalls", 32'(st), 32'd5);
        idle(3);

        // Invalid address: only the decode cycle stalls, nothing written
        q = '{8'hA1, 8'hA2, 8'hA3};
        send_pkt(8'h0F, q, 1'b0, st);
        check_eq("drop_stalls", 32'(st), 32'd1);
        idle(3);

        // Port 0 not empty for 6 cycles: header waits, then written on empty
        fifo_empty[0] = 1'b0;
        push_wr(3'b001, 1'b1, 8'h0C);
        beat(8'h0C, 1'b0, w);
        in_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check_eq("wait_busy", 32'(busy),      32'd1);
            check_eq("wait_nowe", 32'(write_enb), 32'd0);
            @(posedge clk);
            #1;
        end
        fifo_empty[0] = 1'b1;
        @(negedge clk);
        check_eq("wait_hdr_we",  32'(write_enb), 32'd1);
        check_eq("wait_hdr_lfd", 32'(lfd_state), 32'd1);
        @(posedge clk);
        #1;
        x = 8'h0C;
        q = '{8'h01, 8'h02, 8'h03};
        foreach (q[i]) begin
            x ^= q[i];
            push_wr(3'b001, 1'b0, q[i]);
            beat(q[i], 1'b0, w);
        end
        push_wr(3'b001, 1'b0, x);
        exp_fl.push_back('{pe: 1'b0, le: 1'b0});
        beat(x, 1'b1, w);
        in_valid = 1'b0;
        in_last  = 1'b0;
        idle(3);

        // Over-length payload; flush request on another port must be ignored
        soft_reset[0] = 1'b1;
        q = '{8'h5A, 8'hC3, 8'h77};
        send_pkt(8'h09, q, 1'b0, st);
        soft_reset[0] = 1'b0;
        idle(3);

        // Zero-length packets: correct, then one stray payload beat
        q.delete();
        send_pkt(8'h01, q, 1'b0, st);
        idle(3);
        q = '{8'h99};
        send_pkt(8'h01, q, 1'b0, st);
        idle(3);

        // Flush of the destination mid-payload: rest of packet discarded
        push_wr(3'b100, 1'b1, 8'h0E);
        beat(8'h0E, 1'b0, w);
        push_wr(3'b100, 1'b0, 8'h10);
        beat(8'h10, 1'b0, w);
        in_valid      = 1'b0;
        soft_reset[2] = 1'b1;
        @(negedge clk);
        check_eq("srst_nowe", 32'(write_enb), 32'd0);
        @(posedge clk);
        #1;
        soft_reset[2] = 1'b0;
        st = 0;
        beat(8'h20, 1'b0, w);
        st += w;
        beat(8'h30, 1'b0, w);
        st += w;
        beat(8'h2E, 1'b1, w);
        st += w;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("srst_drop_stalls", 32'(st), 32'd0);
        idle(3);

        // Reset in the middle of a packet
        push_wr(3'b010, 1'b1, 8'h0D);
        beat(8'h0D, 1'b0, w);
        push_wr(3'b010, 1'b0, 8'h11);
        beat(8'h11, 1'b0, w);
        in_valid = 1'b0;
        resetn   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("mrst_busy",  32'(busy),      32'd0);
        check_eq("mrst_we",    32'(write_enb), 32'd0);
        check_eq("mrst_lfd",   32'(lfd_state), 32'd0);
        check_eq("mrst_data",  32'(fifo_data), 32'd0);
        check_eq("mrst_flags", 32'({parity_err, len_err, pkt_done}), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(2);

        // Clean packet after reset
        q = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'h0D, q, 1'b0, st);
        check_eq("post_rst_stalls", 32'(st), 32'd1);
        idle(5);

        check_eq("wr_left",    32'(exp_wr.size()), 32'd0);
        check_eq("flags_left", 32'(exp_fl.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
